// File: rtl/player_pkg.sv
// Shared types and default constants for the player action controller.
package player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CROUCH = 2'd1,
        ST_JUMP   = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    localparam int DEF_PUNCH_FRAMES    = 8;
    localparam int DEF_JUMP_FRAMES     = 16;
    localparam int DEF_COOLDOWN_FRAMES = 4;
    localparam int DEF_MAX_HEALTH      = 3;

    // Bit positions inside the packed key vector {punch, jump, crouch, left, right}.
    localparam int KEY_PUNCH  = 4;
    localparam int KEY_JUMP   = 3;
    localparam int KEY_CROUCH = 2;
    localparam int KEY_LEFT   = 1;
    localparam int KEY_RIGHT  = 0;

    // A frame count of zero would make an action invisible, so it behaves as one.
    function automatic int eff_frames(input int frames);
        return (frames < 1) ? 1 : frames;
    endfunction

    // Counter width able to hold the effective frame count.
    function automatic int cnt_width(input int frames);
        return $clog2(eff_frames(frames) + 1);
    endfunction

endpackage

// File: rtl/action_timer.sv
// Load / decrement-on-tick down-counter with a last-tick flag.
// Priority: clear, then load, then decrement. count_next is exposed so the
// parent can register flags that follow the counter in the same cycle.
module action_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             last
);

    // Next count: clear wins over load, load wins over a tick decrement.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_value;
        end else if (tick && (count != '0)) begin
            count_next = count - WIDTH'(1);
        end
    end

    // This tick is the final one of the running interval.
    assign last = tick && (count == WIDTH'(1));

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/player_action_ctrl.sv
// Player action controller: frame-paced state machine for idle / crouch /
// jump / dead, a punch with cooldown, and health tracking driven by hit pulses.
// All outputs are flops loaded from next-state values, so they change in the
// cycle right after the event that causes them.
module player_action_ctrl
    import player_pkg::*;
#(
    parameter int PUNCH_FRAMES    = DEF_PUNCH_FRAMES,
    parameter int JUMP_FRAMES     = DEF_JUMP_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int MAX_HEALTH      = DEF_MAX_HEALTH
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       key_punch,
    input  logic       key_jump,
    input  logic       key_crouch,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       hit,
    input  logic       restart,
    output logic       punch,
    output logic       jump,
    output logic       crouch,
    output logic       left,
    output logic       right,
    output logic       death,
    output logic [1:0] health,
    output logic       busy
);

    localparam int PW = cnt_width(PUNCH_FRAMES);
    localparam int JW = cnt_width(JUMP_FRAMES);
    localparam int CW = cnt_width(COOLDOWN_FRAMES);

    localparam logic [PW-1:0] PUNCH_LOAD  = PW'(eff_frames(PUNCH_FRAMES));
    localparam logic [JW-1:0] JUMP_LOAD   = JW'(eff_frames(JUMP_FRAMES));
    localparam logic [CW-1:0] COOL_LOAD   = CW'(eff_frames(COOLDOWN_FRAMES));
    localparam logic [1:0]    HEALTH_INIT = 2'(eff_frames(MAX_HEALTH));

    state_t      state;
    state_t      state_next;
    logic [4:0]  keys_in;
    logic [4:0]  keys_q;
    logic [4:0]  keys_next;
    logic [1:0]  health_next;
    logic        jump_edge;
    logic        punch_edge;

    logic        jump_load;
    logic        jump_clear;
    logic        punch_load;
    logic        punch_clear;
    logic        cool_load;

    logic [JW-1:0] jump_cnt;
    logic [JW-1:0] jump_cnt_next;
    logic          jump_last;
    logic [PW-1:0] punch_cnt;
    logic [PW-1:0] punch_cnt_next;
    logic          punch_last;
    logic [CW-1:0] cool_cnt;
    logic [CW-1:0] cool_cnt_next;
    logic          cool_last;
    logic          unused_timer_bits;

    logic        moving_next;

    assign keys_in    = {key_punch, key_jump, key_crouch, key_left, key_right};
    assign jump_edge  = keys_in[KEY_JUMP]  & ~keys_q[KEY_JUMP];
    assign punch_edge = keys_in[KEY_PUNCH] & ~keys_q[KEY_PUNCH];

    // Only part of each timer's outputs is needed for jump and cooldown.
    assign unused_timer_bits = ^{jump_cnt, jump_cnt_next, cool_cnt_next, cool_last};

    action_timer #(.WIDTH(JW)) u_jump_timer (
        .clk        (Clk),
        .reset      (Reset),
        .tick       (frame_tick),
        .load       (jump_load),
        .clear      (jump_clear),
        .load_value (JUMP_LOAD),
        .count      (jump_cnt),
        .count_next (jump_cnt_next),
        .last       (jump_last)
    );

    action_timer #(.WIDTH(PW)) u_punch_timer (
        .clk        (Clk),
        .reset      (Reset),
        .tick       (frame_tick),
        .load       (punch_load),
        .clear      (punch_clear),
        .load_value (PUNCH_LOAD),
        .count      (punch_cnt),
        .count_next (punch_cnt_next),
        .last       (punch_last)
    );

    // Cooldown shares the punch clear: entering crouch or death drops both.
    action_timer #(.WIDTH(CW)) u_cool_timer (
        .clk        (Clk),
        .reset      (Reset),
        .tick       (frame_tick),
        .load       (cool_load),
        .clear      (punch_clear),
        .load_value (COOL_LOAD),
        .count      (cool_cnt),
        .count_next (cool_cnt_next),
        .last       (cool_last)
    );

    // Next state, health, key samples and timer controls. Restart and hit act
    // on any cycle; everything else advances only on a frame tick.
    always_comb begin
        state_next  = state;
        keys_next   = keys_q;
        health_next = health;
        jump_load   = 1'b0;
        jump_clear  = 1'b0;
        punch_load  = 1'b0;
        punch_clear = 1'b0;
        cool_load   = 1'b0;

        if (frame_tick) begin
            keys_next = keys_in;
        end

        if (state == ST_DEAD) begin
            if (restart) begin
                state_next  = ST_IDLE;
                health_next = HEALTH_INIT;
                keys_next   = '0;
                jump_clear  = 1'b1;
                punch_clear = 1'b1;
            end
        end else begin
            if (hit && (health != 2'd0)) begin
                health_next = health - 2'd1;
            end

            if (health_next == 2'd0) begin
                state_next  = ST_DEAD;
                jump_clear  = 1'b1;
                punch_clear = 1'b1;
            end else if (frame_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (jump_edge) begin
                            state_next = ST_JUMP;
                            jump_load  = 1'b1;
                        end else if (key_crouch) begin
                            state_next = ST_CROUCH;
                        end
                    end
                    ST_JUMP: begin
                        if (jump_last) begin
                            state_next = key_crouch ? ST_CROUCH : ST_IDLE;
                        end
                    end
                    ST_CROUCH: begin
                        if (!key_crouch) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next = state;
                    end
                endcase

                if ((state != ST_CROUCH) && punch_edge &&
                    (punch_cnt == '0) && (cool_cnt == '0)) begin
                    punch_load = 1'b1;
                end
                if (punch_last) begin
                    cool_load = 1'b1;
                end
                if (state_next == ST_CROUCH) begin
                    punch_clear = 1'b1;
                end
            end
        end
    end

    assign moving_next = (state_next == ST_IDLE) || (state_next == ST_JUMP);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Health, key samples and registered action flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            health <= HEALTH_INIT;
            keys_q <= '0;
            punch  <= 1'b0;
            jump   <= 1'b0;
            crouch <= 1'b0;
            left   <= 1'b0;
            right  <= 1'b0;
            death  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            health <= health_next;
            keys_q <= keys_next;
            punch  <= (punch_cnt_next != '0);
            jump   <= (state_next == ST_JUMP);
            crouch <= (state_next == ST_CROUCH);
            left   <= keys_next[KEY_LEFT] & moving_next;
            right  <= keys_next[KEY_RIGHT] & moving_next;
            death  <= (state_next == ST_DEAD);
            busy   <= (state_next == ST_JUMP) || (punch_cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Bench for player_action_ctrl: vector table, directed multi-cycle sequences,
// and randomized stimulus against a frame-counting reference model.
module tb_player_action_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       key_punch = 1'b0;
    logic       key_jump = 1'b0;
    logic       key_crouch = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       hit = 1'b0;
    logic       restart = 1'b0;
    logic       punch, jump, crouch, left, right, death, busy;
    logic [1:0] health;

    // Key masks in {punch, jump, crouch, left, right} order.
    localparam logic [4:0] KP = 5'b10000;
    localparam logic [4:0] KJ = 5'b01000;
    localparam logic [4:0] KC = 5'b00100;
    localparam logic [4:0] KL = 5'b00010;
    localparam logic [4:0] K0 = 5'b00000;

    localparam int M_PUNCH  = 8;
    localparam int M_JUMP   = 16;
    localparam int M_COOL   = 4;
    localparam int M_HEALTH = 3;

    always #5 Clk = ~Clk;

    player_action_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .key_punch  (key_punch),
        .key_jump   (key_jump),
        .key_crouch (key_crouch),
        .key_left   (key_left),
        .key_right  (key_right),
        .hit        (hit),
        .restart    (restart),
        .punch      (punch),
        .jump       (jump),
        .crouch     (crouch),
        .left       (left),
        .right      (right),
        .death      (death),
        .health     (health),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Output bundle {punch, jump, crouch, left, right, death, busy, health}.
    function automatic logic [8:0] outs();
        return {punch, jump, crouch, left, right, death, busy, health};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; pulses drop after the edge, keys stay.
    task automatic apply(input logic rst, input logic tk, input logic [4:0] k,
                         input logic h, input logic rs);
        Reset      = rst;
        frame_tick = tk;
        {key_punch, key_jump, key_crouch, key_left, key_right} = k;
        hit        = h;
        restart    = rs;
        @(posedge Clk);
        #1;
        Reset      = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        restart    = 1'b0;
    endtask

    // A frame tick followed by an idle cycle.
    task automatic do_tick(input logic [4:0] k);
        apply(1'b0, 1'b1, k, 1'b0, 1'b0);
        apply(1'b0, 1'b0, k, 1'b0, 1'b0);
    endtask

    // ---------------- reference model ----------------
    bit         m_dead, m_crouch;
    int         m_jump_left, m_punch_left, m_cool_left, m_health;
    logic [4:0] m_prev;

    task automatic model_clear_actions();
        m_crouch     = 1'b0;
        m_jump_left  = 0;
        m_punch_left = 0;
        m_cool_left  = 0;
    endtask

    task automatic model_step(input logic rst, input logic tk, input logic [4:0] k,
                              input logic h, input logic rs);
        bit jump_edge, punch_edge, was_jumping, was_crouch, take_punch;
        if (rst) begin
            model_clear_actions();
            m_dead   = 1'b0;
            m_health = M_HEALTH;
            m_prev   = '0;
            return;
        end
        if (m_dead) begin
            if (rs) begin
                m_dead   = 1'b0;
                m_health = M_HEALTH;
                m_prev   = '0;
                model_clear_actions();
            end else if (tk) begin
                m_prev = k;
            end
            return;
        end
        if (h && m_health > 0) m_health--;
        if (m_health == 0) begin
            m_dead = 1'b1;
            model_clear_actions();
            if (tk) m_prev = k;
            return;
        end
        if (!tk) return;
        jump_edge   = (k & KJ) != 0 && (m_prev & KJ) == 0;
        punch_edge  = (k & KP) != 0 && (m_prev & KP) == 0;
        was_jumping = m_jump_left > 0;
        was_crouch  = m_crouch;
        take_punch  = !was_crouch && punch_edge && m_punch_left == 0 && m_cool_left == 0;
        if (m_punch_left > 0) begin
            m_punch_left--;
            if (m_punch_left == 0) m_cool_left = M_COOL;
        end else if (m_cool_left > 0) begin
            m_cool_left--;
        end
        if (was_jumping) begin
            m_jump_left--;
            if (m_jump_left == 0) m_crouch = (k & KC) != 0;
        end else if (was_crouch) begin
            if ((k & KC) == 0) m_crouch = 1'b0;
        end else if (jump_edge) begin
            m_jump_left = M_JUMP;
        end else if ((k & KC) != 0) begin
            m_crouch = 1'b1;
        end
        if (take_punch) m_punch_left = M_PUNCH;
        if (m_crouch) begin
            m_punch_left = 0;
            m_cool_left  = 0;
        end
        m_prev = k;
    endtask

    function automatic logic [8:0] model_outs();
        logic p, j, c, l, r;
        p = !m_dead && m_punch_left > 0;
        j = !m_dead && m_jump_left > 0;
        c = !m_dead && m_crouch;
        l = !m_dead && !m_crouch && m_prev[1];
        r = !m_dead && !m_crouch && m_prev[0];
        return {p, j, c, l, r, m_dead, (p | j), 2'(m_health)};
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       rst;
        logic       tick;
        logic [4:0] keys;
        logic       hit;
        logic       rs;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int cnt;
        logic [4:0] kr;
        logic r, t, h, s;

        //               rst  tick keys hit  rs   {p j c l r d b} health
        tbl[0]  = '{1'b1, 1'b0, K0,     1'b0, 1'b0, 9'b0000000_11};
        tbl[1]  = '{1'b0, 1'b0, K0,     1'b1, 1'b0, 9'b0000000_10};
        tbl[2]  = '{1'b0, 1'b0, K0,     1'b0, 1'b0, 9'b0000000_10};
        tbl[3]  = '{1'b0, 1'b0, K0,     1'b1, 1'b0, 9'b0000000_01};
        tbl[4]  = '{1'b0, 1'b0, K0,     1'b1, 1'b0, 9'b0000010_00};
        tbl[5]  = '{1'b0, 1'b0, K0,     1'b1, 1'b0, 9'b0000010_00};
        tbl[6]  = '{1'b0, 1'b1, KJ,     1'b0, 1'b0, 9'b0000010_00};
        tbl[7]  = '{1'b0, 1'b0, K0,     1'b0, 1'b1, 9'b0000000_11};
        tbl[8]  = '{1'b0, 1'b1, KL,     1'b0, 1'b0, 9'b0001000_11};
        tbl[9]  = '{1'b0, 1'b1, KL|KC,  1'b0, 1'b0, 9'b0010000_11};
        tbl[10] = '{1'b0, 1'b1, K0,     1'b0, 1'b0, 9'b0000000_11};
        tbl[11] = '{1'b0, 1'b1, KJ|KC,  1'b0, 1'b0, 9'b0100001_11};
        tbl[12] = '{1'b1, 1'b1, KJ,     1'b1, 1'b0, 9'b0000000_11};

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].rst, tbl[i].tick, tbl[i].keys, tbl[i].hit, tbl[i].rs);
            check($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Jump lasts exactly 16 ticks; holding the key does not re-trigger.
        apply(1'b1, 1'b0, K0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            do_tick(KJ);
            if (jump) cnt++;
        end
        check("jump_tick_count", 32'(cnt), 32'd16);
        check("jump_held_idle", 32'(outs()), 32'(9'b0000000_11));
        do_tick(K0);
        do_tick(KJ);
        check("jump_repress", 32'(outs()), 32'(9'b0100001_11));

        // Punch for 8 ticks, cooldown rejects edges for 4 ticks, 5th accepted.
        apply(1'b1, 1'b0, K0, 1'b0, 1'b0);
        cnt = 0;
        do_tick(KP);
        if (punch) cnt++;
        for (int i = 0; i < 8; i++) begin
            do_tick(K0);
            if (punch) cnt++;
        end
        check("punch_tick_count", 32'(cnt), 32'd8);
        do_tick(KP);
        check("cool_tick1", 32'(outs()), 32'(9'b0000000_11));
        do_tick(K0);
        do_tick(KP);
        check("cool_tick3", 32'(outs()), 32'(9'b0000000_11));
        do_tick(K0);
        do_tick(KP);
        check("cool_tick5", 32'(outs()), 32'(9'b1000001_11));

        // Punch at jump tick 10 survives the landing.
        apply(1'b1, 1'b0, K0, 1'b0, 1'b0);
        do_tick(KJ);
        for (int i = 1; i < 10; i++) do_tick(KJ);
        do_tick(KJ | KP);
        check("jump_punch_both", 32'(outs()), 32'(9'b1100001_11));
        for (int i = 11; i <= 16; i++) do_tick(KJ);
        check("punch_after_land", 32'(outs()), 32'(9'b1000001_11));
        do_tick(KJ);
        do_tick(KJ);
        check("punch_done", 32'(outs()), 32'(9'b0000000_11));

        // Reset at jump tick 5 with a punch running.
        apply(1'b1, 1'b0, K0, 1'b0, 1'b0);
        do_tick(KJ);
        do_tick(KJ | KP);
        for (int i = 2; i < 5; i++) do_tick(KJ);
        check("pre_reset_active", 32'(outs()), 32'(9'b1100001_11));
        apply(1'b1, 1'b1, KJ | KP, 1'b1, 1'b1);
        check("reset_mid_op", 32'(outs()), 32'(9'b0000000_11));

        // Randomized stimulus against the reference model.
        kr = K0;
        model_step(1'b1, 1'b0, K0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, K0, 1'b0, 1'b0);
        check("rand_reset", 32'(outs()), 32'(model_outs()));
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 5) == 0) kr[b] = ~kr[b];
            end
            r = ($urandom_range(0, 599) == 0);
            t = ($urandom_range(0, 2) == 0);
            h = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 24) == 0);
            model_step(r, t, kr, h, s);
            apply(r, t, kr, h, s);
            check("random", 32'(outs()), 32'(model_outs()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/player_action_ctrl.md
PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 SHALL expose these parameters (name, default, meaning):
- PUNCH_FRAMES, 8: frames punch is held.
- JUMP_FRAMES, 16: frames jump is held.
- COOLDOWN_FRAMES, 4: frames after a punch before another is accepted.
- MAX_HEALTH, 3: health loaded at reset and at restart.
REQ-002 SHALL expose these ports (name, direction, width, meaning):
- Clk, in, 1: single system clock.
- Reset, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per video frame.
- key_punch, key_jump, key_crouch, key_left, key_right, in, 1 each: level-sensitive player keys.
- hit, in, 1: one-cycle damage pulse.
- restart, in, 1: leave death state.
- punch, jump, crouch, left, right, death, out, 1 each: action flags for sprite selection.
- health, out, 2: remaining health.
- busy, out, 1: jump or punch in progress.

Function
REQ-003 SHALL implement states ST_IDLE, ST_CROUCH, ST_JUMP, ST_DEAD.
REQ-004 SHALL change state, timers and key samples only on Clk edges where frame_tick=1, except the hit, restart and Reset behaviour defined below.
REQ-005 SHALL register all outputs, so an output changes one Clk cycle after the frame_tick cycle that causes the change.
REQ-006 SHALL register each key at every frame_tick; a key edge is current=1 with previous sample=0.
REQ-007 IDLE: a key_jump edge SHALL go to JUMP and load jump_cnt=JUMP_FRAMES; otherwise key_crouch=1 SHALL go to CROUCH; jump SHALL win when both occur together.
REQ-008 JUMP: jump_cnt SHALL decrement on each tick; on the tick where jump_cnt=1 the state SHALL go to CROUCH if key_crouch=1, else IDLE, so jump is high for exactly JUMP_FRAMES ticks.
REQ-009 CROUCH: key_crouch=0 at a tick SHALL return to IDLE; jump and punch requests SHALL be ignored.
REQ-010 Punch SHALL be accepted on a key_punch edge only when in IDLE or JUMP, punch_cnt=0 and cool_cnt=0; acceptance loads punch_cnt=PUNCH_FRAMES.
REQ-011 punch_cnt SHALL decrement on each tick; on the tick where punch_cnt=1, cool_cnt SHALL be loaded with COOLDOWN_FRAMES; cool_cnt SHALL then decrement on each tick to 0.
REQ-012 A punch SHALL continue across a JUMP-to-IDLE transition, and SHALL be cleared (punch_cnt=0, cool_cnt=0) on entry to CROUCH or DEAD.
REQ-013 hit SHALL be sampled on any cycle; health SHALL decrement, saturating at 0; hit SHALL be ignored in DEAD.
REQ-014 When health reaches 0, the state SHALL go to DEAD on the next cycle, without waiting for frame_tick and from any state.
REQ-015 DEAD SHALL be absorbing; restart=1 on any cycle SHALL go to IDLE, reload health=MAX_HEALTH and clear all timers and key samples.
REQ-016 Output mapping:
- jump = (state==JUMP).
- crouch = (state==CROUCH).
- death = (state==DEAD).
- punch = (punch_cnt != 0).
- left, right = registered key samples, forced 0 in CROUCH and DEAD.
- In DEAD, all flags except death SHALL be 0.
- busy = jump | punch.
REQ-017 A parameter value of 0 SHALL be treated as 1; all counters SHALL be wide enough for their parameter.

Reset
REQ-018 Reset=1 at a Clk edge SHALL force:
- state = IDLE;
- health = MAX_HEALTH;
- all counters and key samples = 0;
- all action flags and busy = 0.
REQ-019 Reset SHALL override hit, restart and frame_tick on the same cycle, including mid-jump and mid-punch.

Structure
REQ-020 A shared package player_pkg SHALL hold the state enum and the default parameter constants.
REQ-021 A single reusable sub-module action_timer SHALL be used: a load/decrement-on-tick down-counter with a last-tick flag, instantiated for jump, punch and cooldown.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Jump: key_jump edge at tick T -> jump=1 from T+1 cycle for exactly 16 ticks, then IDLE; holding key_jump causes no re-jump until it is released.
- Punch and cooldown: punch edge -> punch=1 for 8 ticks; a second edge within the next 4 ticks is ignored; an edge at tick 5 after the punch ends is accepted.
- Jump+punch and crouch priority: punch at jump tick 10 -> jump and punch both high, punch survives landing; jump and crouch pressed in the same tick -> jump only.
- Death: three hit pulses with no frame_tick -> health 3,2,1,0, death=1 one cycle after the third hit; further hits leave health=0; restart -> IDLE, health=3.
- Reset mid-operation: Reset during jump tick 5 with punch active -> all outputs 0 and health=3 the next cycle.
